// File: rtl/seq_alu.sv
// Multi-cycle ALU with a start/done handshake. ADD, SUB and the logic ops
// finish one cycle after start. MUL (radix-2 Booth, signed) and DIV
// (restoring, unsigned) iterate WIDTH times and then complete.
// Optional feature macro: ALU_SHIFT_EN adds the shift and rotate opcodes 7-11.
module seq_alu #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB = 5'd1,  OP_DIV = 5'd2,  OP_AND = 5'd3,
    OP_OR   = 5'd4,  OP_XOR = 5'd5,  OP_MUL = 5'd6,  OP_SHL = 5'd7,
    OP_SHR  = 5'd8,  OP_SHRA = 5'd9, OP_ROL = 5'd10, OP_ROR = 5'd11
  } op_e;

  state_e           state, state_n;
  // acc is the Booth accumulator during MUL and the partial remainder during DIV
  logic [WIDTH:0]   acc, acc_n;
  logic [WIDTH-1:0] q, q_n;
  logic [WIDTH-1:0] m, m_n;
  logic             qm1, qm1_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] lo_n, hi_n;
  logic             c_n, dz_n, done_n;

  logic [WIDTH-1:0] sc_lo;
  logic             sc_c;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   m_ext, booth_sum, rem_sh;
  logic [WIDTH+1:0] trial;

`ifdef ALU_SHIFT_EN
  localparam int SH_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [SH_W-1:0]  sh;
  assign sh = b[SH_W-1:0];
`endif

  assign busy = (state == S_MUL) || (state == S_DIV);

  // Single-cycle result and carry, computed straight from the live operands
  always_comb begin
    sc_lo    = a;
    sc_c     = 1'b0;
    add_full = {1'b0, a} + {1'b0, b};
    case (op)
      OP_ADD: begin sc_lo = add_full[WIDTH-1:0]; sc_c = add_full[WIDTH]; end
      OP_SUB: begin sc_lo = a - b; sc_c = (a >= b); end
      OP_AND: sc_lo = a & b;
      OP_OR:  sc_lo = a | b;
      OP_XOR: sc_lo = a ^ b;
`ifdef ALU_SHIFT_EN
      OP_SHL: begin
        sc_lo = a << sh;
        if (sh != '0) sc_c = |(a & (ONE << (WIDTH - int'(sh))));
      end
      OP_SHR: begin
        sc_lo = a >> sh;
        if (sh != '0) sc_c = |(a & (ONE << (sh - 1'b1)));
      end
      OP_SHRA: begin
        sc_lo = $signed(a) >>> sh;
        if (sh != '0) sc_c = |(a & (ONE << (sh - 1'b1)));
      end
      OP_ROL: sc_lo = (a << sh) | (a >> (WIDTH - int'(sh)));
      OP_ROR: sc_lo = (a >> sh) | (a << (WIDTH - int'(sh)));
`endif
      default: ;
    endcase
  end

  // Next-state, iteration datapath and registered outputs
  always_comb begin
    state_n = state;
    acc_n   = acc;
    q_n     = q;
    m_n     = m;
    qm1_n   = qm1;
    cnt_n   = cnt;
    lo_n    = result_lo;
    hi_n    = result_hi;
    c_n     = carry_out;
    dz_n    = div_by_zero;
    done_n  = 1'b0;

    m_ext = {m[WIDTH-1], m};
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
    rem_sh = {acc[WIDTH-1:0], q[WIDTH-1]};
    trial  = {1'b0, rem_sh} - {2'b00, m};

    case (state)
      // FIN accepts a new start exactly like IDLE so back-to-back ops work
      S_IDLE, S_FIN: begin
        state_n = S_IDLE;
        if (start) begin
          if (op == OP_MUL) begin
            acc_n   = '0;
            q_n     = b;
            qm1_n   = 1'b0;
            m_n     = a;
            cnt_n   = CNT_W'(WIDTH);
            state_n = S_MUL;
          end else if (op == OP_DIV && b != '0) begin
            acc_n   = '0;
            q_n     = a;
            m_n     = b;
            cnt_n   = CNT_W'(WIDTH);
            state_n = S_DIV;
          end else if (op == OP_DIV) begin
            lo_n   = '1;
            hi_n   = a;
            c_n    = 1'b0;
            dz_n   = 1'b1;
            done_n = 1'b1;
          end else begin
            lo_n   = sc_lo;
            hi_n   = '0;
            c_n    = sc_c;
            dz_n   = 1'b0;
            done_n = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_n = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q_n   = {booth_sum[0], q[WIDTH-1:1]};
        qm1_n = q[0];
        cnt_n = cnt - 1'b1;
      end
      S_DIV: begin
        acc_n = trial[WIDTH+1] ? rem_sh : trial[WIDTH:0];
        q_n   = {q[WIDTH-2:0], ~trial[WIDTH+1]};
        cnt_n = cnt - 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // The last iteration writes the result at the same edge it enters FIN,
    // so done and the result are both visible during the FIN cycle.
    if ((state == S_MUL || state == S_DIV) && cnt == CNT_W'(1)) begin
      state_n = S_FIN;
      lo_n    = q_n;
      hi_n    = acc_n[WIDTH-1:0];
      c_n     = 1'b0;
      dz_n    = 1'b0;
      done_n  = 1'b1;
    end
  end

  // State and output registers with synchronous clear
  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= S_IDLE;
      acc         <= '0;
      q           <= '0;
      m           <= '0;
      qm1         <= 1'b0;
      cnt         <= '0;
      result_lo   <= '0;
      result_hi   <= '0;
      carry_out   <= 1'b0;
      div_by_zero <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      q           <= q_n;
      m           <= m_n;
      qm1         <= qm1_n;
      cnt         <= cnt_n;
      result_lo   <= lo_n;
      result_hi   <= hi_n;
      carry_out   <= c_n;
      div_by_zero <= dz_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed vector table, randomized ops against a
// plain-arithmetic reference model, and hand-written handshake sequences.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         clr, start;
  logic [4:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, carry_out, div_by_zero;
  logic [W-1:0] result_lo, result_hi;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .carry_out(carry_out), .div_by_zero(div_by_zero)
  );

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model from the arithmetic definitions of each opcode
  function automatic void model(input logic [4:0] o, input logic [W-1:0] x, y,
                                output logic [W-1:0] lo, hi, output logic c, dz);
    logic [32:0] w;
    longint p;
    logic [63:0] t;
    logic signed [63:0] s;
    int amt;
    lo = x; hi = '0; c = 1'b0; dz = 1'b0;
    amt = int'(y[4:0]);
    t = '0; s = '0; w = '0; p = 0;
    case (o)
      5'd0: begin w = {1'b0, x} + {1'b0, y}; lo = w[31:0]; c = w[32]; end
      5'd1: begin lo = x - y; c = (x >= y); end
      5'd2: if (y == 0) begin lo = '1; hi = x; dz = 1'b1; end
            else begin lo = x / y; hi = x % y; end
      5'd3: lo = x & y;
      5'd4: lo = x | y;
      5'd5: lo = x ^ y;
      5'd6: begin p = longint'($signed(x)) * longint'($signed(y)); {hi, lo} = p; end
`ifdef ALU_SHIFT_EN
      5'd7:  begin t = {32'b0, x} << amt; lo = t[31:0]; c = (amt != 0) && t[32]; end
      5'd8:  begin t = {x, 32'b0} >> amt; lo = t[63:32]; c = (amt != 0) && t[31]; end
      5'd9:  begin s = {x, 32'b0}; s = s >>> amt; lo = s[63:32]; c = (amt != 0) && s[31]; end
      5'd10: begin t = {x, x} << amt; lo = t[63:32]; end
      5'd11: begin t = {x, x} >> amt; lo = t[31:0]; end
`endif
      default: ;
    endcase
  endfunction

  // Launch one op, scramble the operands afterwards, wait (bounded) for done
  task automatic do_op(input logic [4:0] o, input logic [W-1:0] x, y,
                       output int lat, output int bcnt);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    lat = 1; bcnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a, b, lo, hi;
    logic         c, dz;
    int           lat;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int lat, bcnt, exp_lat, seen;
    logic [4:0] o;
    logic [W-1:0] x, y, elo, ehi, held;
    logic ec, edz;

    tbl[0] = '{5'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 32'h0, 1'b1, 1'b0, 1};
    tbl[1] = '{5'd1, 32'd5, 32'd7, 32'hFFFFFFFE, 32'h0, 1'b0, 1'b0, 1};
    tbl[2] = '{5'd6, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, 33};
    tbl[3] = '{5'd6, 32'h80000000, 32'h80000000, 32'h0, 32'h40000000, 1'b0, 1'b0, 33};
    tbl[4] = '{5'd2, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 33};
    tbl[5] = '{5'd2, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b0, 1'b1, 1};
`ifdef ALU_SHIFT_EN
    tbl[6] = '{5'd9, 32'h80000000, 32'd4, 32'hF8000000, 32'h0, 1'b0, 1'b0, 1};
`else
    tbl[6] = '{5'd9, 32'h80000000, 32'd4, 32'h80000000, 32'h0, 1'b0, 1'b0, 1};
`endif
    tbl[7] = '{5'd31, 32'h1234, 32'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 1};
    tbl[8] = '{5'd1, 32'd7, 32'd7, 32'h0, 32'h0, 1'b1, 1'b0, 1};
    tbl[9] = '{5'd3, 32'hF0F0, 32'hFF00, 32'hF000, 32'h0, 1'b0, 1'b0, 1};

    // Reset, with start held high to show clr wins
    clr = 1'b1; start = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_lo", 64'(result_lo), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_c", 64'(carry_out), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    clr = 1'b0; start = 1'b0;

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, bcnt);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("vec%0d_busy", i), 64'(bcnt), (tbl[i].lat == 33) ? 64'd32 : 64'd0);
      chk($sformatf("vec%0d_lo", i), 64'(result_lo), 64'(tbl[i].lo));
      chk($sformatf("vec%0d_hi", i), 64'(result_hi), 64'(tbl[i].hi));
      chk($sformatf("vec%0d_c", i), 64'(carry_out), 64'(tbl[i].c));
      chk($sformatf("vec%0d_dz", i), 64'(div_by_zero), 64'(tbl[i].dz));
    end

    // Randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      o = 5'($urandom_range(0, 13));
      if (o == 5'd13) o = 5'($urandom_range(12, 31));
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 7))
        0: y = '0;
        1: y = y & 32'hF;
        2: x = 32'h80000000;
        default: ;
      endcase
      model(o, x, y, elo, ehi, ec, edz);
      exp_lat = (o == 5'd6 || (o == 5'd2 && y != 0)) ? 33 : 1;
      do_op(o, x, y, lat, bcnt);
      chk($sformatf("rnd%0d_op%0d_lat", i, o), 64'(lat), 64'(exp_lat));
      chk($sformatf("rnd%0d_op%0d_lo", i, o), 64'(result_lo), 64'(elo));
      chk($sformatf("rnd%0d_op%0d_hi", i, o), 64'(result_hi), 64'(ehi));
      chk($sformatf("rnd%0d_op%0d_c", i, o), 64'(carry_out), 64'(ec));
      chk($sformatf("rnd%0d_op%0d_dz", i, o), 64'(div_by_zero), 64'(edz));
      chk($sformatf("rnd%0d_busy_at_done", i), 64'(busy), 64'd0);
      @(negedge clk);
      chk($sformatf("rnd%0d_done_pulse", i), 64'(done), 64'd0);
      chk($sformatf("rnd%0d_hold", i), 64'(result_lo), 64'(elo));
    end

    // Start re-pulsed during a MUL is ignored
    @(negedge clk);
    op = 5'd6; a = 32'hFFFFFFFD; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      if (lat == 5) begin start = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1; end
      else start = 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("repulse_lat", 64'(lat), 64'd33);
    chk("repulse_lo", 64'(result_lo), 64'hFFFFFFEB);
    chk("repulse_hi", 64'(result_hi), 64'hFFFFFFFF);

    // Back-to-back: start in the done cycle is accepted
    op = 5'd0; a = 32'd10; b = 32'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done", 64'(done), 64'd1);
    chk("b2b_lo", 64'(result_lo), 64'd30);
    chk("b2b_hi", 64'(result_hi), 64'd0);
    @(negedge clk);
    chk("b2b_done_low", 64'(done), 64'd0);

    // clr in the middle of a MUL
    op = 5'd6; a = 32'd12345; b = 32'd678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_clr_busy", 64'(busy), 64'd1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_done", 64'(done), 64'd0);
    chk("clr_lo", 64'(result_lo), 64'd0);
    chk("clr_hi", 64'(result_hi), 64'd0);
    chk("clr_c", 64'(carry_out), 64'd0);
    chk("clr_dz", 64'(div_by_zero), 64'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    chk("clr_no_done", 64'(seen), 64'd0);

    do_op(5'd0, 32'd2, 32'd3, lat, bcnt);
    chk("add_after_clr_lat", 64'(lat), 64'd1);
    chk("add_after_clr_lo", 64'(result_lo), 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
